// File: rtl/button_event_decoder_pkg.sv
// Shared button types and default timing constants.
// Imported by every block that consumes debounced buttons.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_e;

  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;
  localparam int unsigned CNT_W_DEF         = 26;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, one-clock game events out.
// master = decoder side, slave = game control side.
interface button_if;

  logic cleanb;
  logic press_pulse;
  logic release_pulse;
  logic tap_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    input  cleanb,
    output press_pulse,
    output release_pulse,
    output tap_pulse,
    output long_pulse,
    output repeat_pulse,
    output held
  );

  modport slave (
    output cleanb,
    input  press_pulse,
    input  release_pulse,
    input  tap_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held
  );

endinterface

// File: rtl/button_event_decoder_edge_detect.sv
// Single-bit rise/fall detector against a registered copy.
// prev resets to 0 so a level already high reads as a rise.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;
  assign o_fall = ~i_d & r_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/tap/long/repeat pulses.
// A fall always beats a threshold hit in the same cycle.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  button_if.master bus
);

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic r_press, r_release, r_tap, r_long, r_repeat;
  logic w_press, w_release, w_tap, w_long, w_repeat;
  logic w_rise, w_fall;

  edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (bus.cleanb),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_tap     <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_tap     <= w_tap;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_tap       = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_press     = 1'b1;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
          w_tap       = 1'b1;
        end else if (r_cnt == LONG_M1) begin
          w_state_nxt = LONG;
          w_cnt_nxt   = '0;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      LONG: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
        end else if (r_cnt == REP_M1) begin
          w_cnt_nxt = '0;
          w_repeat  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.tap_pulse     = r_tap;
  assign bus.long_pulse    = r_long;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.held          = (r_state != IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized and directed bench for button_event_decoder.
// Reference model tracks hold age since press, not FSM state.
module tb_button_event_decoder;

  localparam int LONG_C = 8;
  localparam int REP_C  = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  button_if bif ();

  button_event_decoder #(
    .LONG_CYCLES   (LONG_C),
    .REPEAT_CYCLES (REP_C),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: m_hold = button considered held, m_age = edges since press
  bit m_prev;
  bit m_hold;
  int m_age;

  task automatic model_reset();
    m_prev = 1'b0;
    m_hold = 1'b0;
    m_age  = 0;
  endtask

  // vector order: press, release, tap, long, repeat, held
  task automatic model_step(input bit c, output logic [5:0] e);
    bit p, r, t, l, rp;
    p = 0; r = 0; t = 0; l = 0; rp = 0;
    if (!m_hold) begin
      if (c && !m_prev) begin
        p = 1; m_hold = 1; m_age = 0;
      end
    end else if (!c) begin
      r = 1;
      t = (m_age < LONG_C);
      m_hold = 0;
    end else begin
      m_age++;
      l  = (m_age == LONG_C);
      rp = (m_age > LONG_C) && (((m_age - LONG_C) % REP_C) == 0);
    end
    m_prev = c;
    e = {p, r, t, l, rp, m_hold};
  endtask

  function automatic logic [5:0] dut_vec();
    return {bif.press_pulse, bif.release_pulse, bif.tap_pulse,
            bif.long_pulse, bif.repeat_pulse, bif.held};
  endfunction

  // called at a negedge; returns at the following negedge
  task automatic drive_cycle(input bit c,
                             output logic [5:0] e,
                             output logic [5:0] g);
    bif.cleanb = c;
    @(posedge clk);
    model_step(c, e);
    #1;
    g = dut_vec();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [5:0] g;
    rst_n      = 1'b0;
    bif.cleanb = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    g = dut_vec();
    checks++;
    if (g !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", g, 6'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tap();
    logic [5:0] e, g;
    int held_n;
    int pat[5] = '{1, 1, 1, 0, 0};
    held_n = 0;
    foreach (pat[i]) begin
      drive_cycle(pat[i][0], e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL tap_cyc%0d got=%b exp=%b", i, g, e);
      end
      if (g[0]) held_n++;
    end
    checks++;
    if (held_n !== 3) begin
      errors++;
      $display("FAIL tap_held_len got=%0d exp=3", held_n);
    end
  endtask

  task automatic test_long_repeat();
    logic [5:0] e, g;
    int long_at, rel_at, tap_at_rel;
    int reps[$];
    long_at = -1; rel_at = -1; tap_at_rel = -1;
    for (int k = 0; k < 23; k++) begin
      drive_cycle(k < 20, e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL long_cyc%0d got=%b exp=%b", k, g, e);
      end
      if (g[2]) long_at = k;
      if (g[1]) reps.push_back(k);
      if (g[4] && rel_at < 0) begin
        rel_at = k;
        tap_at_rel = int'(g[3]);
      end
    end
    checks++;
    if (long_at !== 8 || rel_at !== 20 || tap_at_rel !== 0) begin
      errors++;
      $display("FAIL long_timing long=%0d rel=%0d tap=%0d exp 8/20/0",
               long_at, rel_at, tap_at_rel);
    end
    checks++;
    if (reps.size() != 2 || reps[0] != 12 || reps[1] != 16) begin
      errors++;
      $display("FAIL repeat_timing n=%0d exp 2 at 12,16", reps.size());
    end
  endtask

  task automatic test_race(input int high_n, input string nm,
                           input bit exp_tap);
    logic [5:0] e, g;
    for (int k = 0; k <= high_n + 1; k++) begin
      drive_cycle(k < high_n, e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s_cyc%0d got=%b exp=%b", nm, k, g, e);
      end
      if (k == high_n) begin
        checks++;
        if (g !== {1'b0, 1'b1, exp_tap, 3'b000}) begin
          errors++;
          $display("FAIL %s_fall got=%b exp=%b", nm, g,
                   {1'b0, 1'b1, exp_tap, 3'b000});
        end
      end
    end
  endtask

  task automatic test_reset_midhold();
    logic [5:0] e, g;
    for (int k = 0; k < 10; k++) drive_cycle(1'b1, e, g);
    rst_n = 1'b0;
    #1;
    g = dut_vec();
    checks++;
    if (g !== 6'b0) begin
      errors++;
      $display("FAIL midhold_rst got=%b exp=%b", g, 6'b0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== 6'b0) begin
      errors++;
      $display("FAIL midhold_rst_hold got=%b exp=0", dut_vec());
    end
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive_cycle(k < 9, e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL after_rst_cyc%0d got=%b exp=%b", k, g, e);
      end
      if (k == 0 && g[5] !== 1'b1) begin
        errors++;
        $display("FAIL after_rst_press got=%b exp=1", g[5]);
      end
      if (k == 8 && g[2] !== 1'b1) begin
        errors++;
        $display("FAIL after_rst_long got=%b exp=1", g[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e, g;
    int np, nt, nr;
    int pat[5] = '{1, 0, 1, 0, 0};
    np = 0; nt = 0; nr = 0;
    foreach (pat[i]) begin
      drive_cycle(pat[i][0], e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_cyc%0d got=%b exp=%b", i, g, e);
      end
      np += int'(g[5]);
      nr += int'(g[4]);
      nt += int'(g[3]);
    end
    checks++;
    if (np !== 2 || nr !== 2 || nt !== 2) begin
      errors++;
      $display("FAIL b2b_counts p=%0d r=%0d t=%0d exp 2/2/2", np, nr, nt);
    end
  endtask

  task automatic test_random();
    logic [5:0] e, g;
    bit lvl;
    int len;
    lvl = 1'b0;
    for (int b = 0; b < 40; b++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 22);
      for (int k = 0; k < len; k++) begin
        drive_cycle(lvl, e, g);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL rand_b%0d_k%0d got=%b exp=%b", b, k, g, e);
        end
        checks++;
        if ((int'(g[5]) + int'(g[2]) + int'(g[1])) > 1 ||
            (g[3] && !g[4])) begin
          errors++;
          $display("FAIL rand_exclusive got=%b exp=one-hot events", g);
        end
      end
    end
    drive_cycle(1'b0, e, g);
    drive_cycle(1'b0, e, g);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    @(negedge clk);
    test_tap();
    test_long_repeat();
    test_race(8, "race_pressed", 1'b1);
    test_race(12, "race_long", 1'b0);
    test_reset_midhold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
